// File: rtl/uart_pkg.sv
// Shared types and the parity helper for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_BRK_MARK
  } state_t;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK} parity_t;

  typedef enum logic [1:0] {STOP_1, STOP_1P5, STOP_2, STOP_2X} stop_t;

  // cfg_dbits is 4 bits wide, so no frame can use more than 15 data bits.
  localparam int PAR_W = 16;

  function automatic logic calc_parity(input logic [PAR_W-1:0] din,
                                       input logic [3:0]       dbits,
                                       input parity_t          mode);
    logic x;
    logic p;
    x = 1'b0;
    for (int i = 0; i < PAR_W; i++) begin
      if (i < int'(dbits)) x ^= din[i];
    end
    case (mode)
      PAR_EVEN: p = x;
      PAR_ODD:  p = ~x;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..DBIT_MAX data bits, none/even/odd/mark parity,
// 1/1.5/2 stop bits, ready/valid handshake, CTS hold-off and break generation.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = 9,
  parameter int OS       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                tx_start,
  output logic                tx_ready,
  input  logic [DBIT_MAX-1:0] din,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic [1:0]          cfg_stop,
  input  logic                cts,
  input  logic                send_break,
  output logic                tx_done_tick,
  output logic                tx_busy,
  output logic                tx
);

  localparam int TW = $clog2(2 * OS);
  localparam int NW = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;
  localparam logic [TW-1:0] OS_LAST = TW'(OS - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [NW-1:0]       n_q, n_d;
  logic [DBIT_MAX-1:0] shift_q, shift_d;
  logic [NW-1:0]       nlast_q, nlast_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic [TW-1:0]       stop_last_q, stop_last_d;
  logic                tx_q, tx_d;
  logic                done;
  logic [3:0]          dbits_cl;
  logic                os_end;

  always_comb begin
    dbits_cl = cfg_dbits;
    if (cfg_dbits < 4'd5) dbits_cl = 4'd5;
    else if (int'(cfg_dbits) > DBIT_MAX) dbits_cl = 4'(DBIT_MAX);
  end

  assign tx_ready = (state_q == ST_IDLE) & ~send_break & ~cts;
  assign os_end   = s_tick & (tick_q == OS_LAST);

  // tx is registered from the next-state decision so the line changes on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    n_d         = n_q;
    shift_d     = shift_q;
    nlast_d     = nlast_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop_last_d = stop_last_q;
    tx_d        = tx_q;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (send_break) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
        end else if (tx_start && tx_ready) begin
          state_d   = ST_START;
          tx_d      = 1'b0;
          tick_d    = '0;
          shift_d   = din;
          nlast_d   = NW'(dbits_cl - 4'd1);
          par_en_d  = (parity_t'(cfg_parity) != PAR_NONE);
          par_bit_d = calc_parity(PAR_W'(din), dbits_cl, parity_t'(cfg_parity));
          case (stop_t'(cfg_stop))
            STOP_1:   stop_last_d = OS_LAST;
            STOP_1P5: stop_last_d = TW'(3 * OS / 2 - 1);
            default:  stop_last_d = TW'(2 * OS - 1);
          endcase
        end
      end
      ST_START: begin
        if (os_end) begin
          state_d = ST_DATA;
          tick_d  = '0;
          n_d     = '0;
          tx_d    = shift_q[0];
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (os_end) begin
          tick_d = '0;
          if (n_q == nlast_q) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            n_d     = n_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (os_end) begin
          state_d = ST_STOP;
          tick_d  = '0;
          tx_d    = 1'b1;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (s_tick && (tick_q == stop_last_q)) begin
          state_d = ST_IDLE;
          tick_d  = '0;
          done    = 1'b1;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_BREAK: begin
        tx_d = 1'b0;
        if (!send_break) begin
          state_d = ST_BRK_MARK;
          tick_d  = '0;
          tx_d    = 1'b1;
        end
      end
      ST_BRK_MARK: begin
        if (os_end) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      n_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
    end
  end

  // Frame payload and latched configuration; only meaningful while a frame is active.
  always_ff @(posedge clk) begin
    shift_q     <= shift_d;
    nlast_q     <= nlast_d;
    par_en_q    <= par_en_d;
    par_bit_q   <= par_bit_d;
    stop_last_q <= stop_last_d;
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done & ~reset;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: per-tick line levels are predicted from the frame format.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int DBIT_MAX = 9;
  localparam int OS       = 16;

  typedef struct packed {
    logic [255:0] lv;
    int           len;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic       tx_ready;
  logic [8:0] din;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic [1:0] cfg_stop;
  logic       cts;
  logic       send_break;
  logic       tx_done_tick;
  logic       tx_busy;
  logic       tx;

  int tests = 0;
  int fails = 0;
  int tper  = 4;
  int tcnt  = 0;
  frame_t expq[$];
  bit b2b_chk = 1'b0;
  int cyc = 0;
  int last_done_cyc = -10;

  uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OS(OS)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .tx_ready(tx_ready),
    .din(din), .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
    .cts(cts), .send_break(send_break), .tx_done_tick(tx_done_tick), .tx_busy(tx_busy), .tx(tx)
  );

  initial forever #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tcnt++;
      if (tcnt >= tper) begin
        tcnt = 0;
        s_tick = 1'b1;
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected line level at each s_tick of a frame: start, data LSB first, parity, stop.
  function automatic frame_t model(input logic [8:0] d, input int db, input int par, input int stp);
    frame_t f;
    int nd, k, ones, nst;
    logic pb;
    nd   = (db < 5) ? 5 : ((db > DBIT_MAX) ? DBIT_MAX : db);
    ones = 0;
    for (int i = 0; i < nd; i++) ones += int'(d[i]);
    if (par == 1)      pb = (ones % 2 == 1);
    else if (par == 2) pb = (ones % 2 == 0);
    else               pb = 1'b1;
    nst  = (stp == 0) ? OS : ((stp == 1) ? (3 * OS) / 2 : 2 * OS);
    f.lv = '0;
    k    = 0;
    for (int t = 0; t < OS; t++) begin f.lv[k] = 1'b0; k++; end
    for (int i = 0; i < nd; i++)
      for (int t = 0; t < OS; t++) begin f.lv[k] = d[i]; k++; end
    if (par != 0)
      for (int t = 0; t < OS; t++) begin f.lv[k] = pb; k++; end
    for (int t = 0; t < nst; t++) begin f.lv[k] = 1'b1; k++; end
    f.len = k;
    return f;
  endfunction

  initial begin : monitor
    logic [255:0] cap;
    int clen;
    bit capt;
    frame_t e;
    cap = '0; clen = 0; capt = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        check("done_in_reset", 256'(tx_done_tick), 256'(0));
        capt = 1'b0;
        expq.delete();
      end else begin
        if (capt && s_tick && tx_busy && clen < 256) begin
          cap[clen] = tx;
          clen++;
        end
        if (tx_done_tick) begin
          check("done_has_frame", 256'(capt && (expq.size() > 0)), 256'(1));
          if (capt && (expq.size() > 0)) begin
            e = expq.pop_front();
            check("frame_ticks", 256'(clen), 256'(e.len));
            check("frame_levels", cap, e.lv);
          end
          capt = 1'b0;
          last_done_cyc = cyc;
        end
        if (tx_start && tx_ready) begin
          if (b2b_chk) begin
            check("b2b_gap", 256'(cyc - last_done_cyc), 256'(1));
            b2b_chk = 1'b0;
          end
          capt = 1'b1;
          clen = 0;
          cap  = '0;
        end
      end
    end
  end

  task automatic send(input logic [8:0] d, input int db, input int par, input int stp);
    int n;
    expq.push_back(model(d, db, par, stp));
    din = d; cfg_dbits = 4'(db); cfg_parity = 2'(par); cfg_stop = 2'(stp);
    tx_start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("accept_timeout", 256'(tx_ready), 256'(1));
    @(posedge clk); #1;
    tx_start   = 1'b0;
    din        = 9'($urandom);
    cfg_dbits  = 4'($urandom);
    cfg_parity = 2'($urandom);
    cfg_stop   = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 256'(tx_busy), 256'(0));
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int lo, hi, dn, cnt;
    bit blk;
    int gap, k;
    reset = 1'b1; tx_start = 1'b0; din = '0; cfg_dbits = '0; cfg_parity = '0; cfg_stop = '0;
    cts = 1'b0; send_break = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx", 256'(tx), 256'(1));
    check("rst_busy", 256'(tx_busy), 256'(0));
    check("rst_done", 256'(tx_done_tick), 256'(0));
    reset = 1'b0;
    check("rst_ready", 256'(tx_ready), 256'(1));

    // 8N1 0x55 with clock-level busy/done measurement
    send(9'h055, 8, 0, 0);
    check("8n1_start_low", 256'(tx), 256'(0));
    cnt = 0; dn = 0;
    while (tx_busy && cnt < 2000) begin
      @(negedge clk);
      if (tx_busy) begin
        cnt++;
        dn += int'(tx_done_tick);
      end
    end
    check("8n1_busy_clk", 256'(cnt >= 637 && cnt <= 640), 256'(1));
    check("8n1_done_count", 256'(dn), 256'(1));
    @(posedge clk); #1;

    // 7E2 then 7O1 back-to-back, 9-bit mark 1.5 stop, clamped widths
    send(9'h003, 7, 1, 2);
    b2b_chk = 1'b1;
    send(9'h003, 7, 2, 0);
    wait_idle();
    send(9'h1FF, 9, 3, 1);
    wait_idle();
    send(9'h0E5, 3, 1, 0);
    wait_idle();
    send(9'h155, 15, 2, 3);
    wait_idle();

    // CTS hold-off, release, then CTS raised mid-frame
    cts = 1'b1;
    expq.push_back(model(9'h0A6, 8, 1, 0));
    din = 9'h0A6; cfg_dbits = 4'd8; cfg_parity = 2'd1; cfg_stop = 2'd0; tx_start = 1'b1;
    lo = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b0) lo++;
    end
    check("cts_hold", 256'(lo), 256'(0));
    @(posedge clk); #1;
    cts = 1'b0;
    @(posedge clk); #1;
    check("cts_release_start", 256'(tx), 256'(0));
    tx_start = 1'b0;
    repeat (200) @(posedge clk); #1;
    cts = 1'b1;
    wait_idle();
    cts = 1'b0;

    // Break for 300 clk from IDLE
    send_break = 1'b1;
    lo = 0; hi = 0; dn = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) check("brk_ready_low", 256'(tx_ready), 256'(0));
      if (tx === 1'b0) lo++;
    end
    @(posedge clk); #1;
    send_break = 1'b0;
    cnt = 0;
    while (cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (!tx_busy) break;
      if (tx === 1'b0) lo++;
      else hi++;
      dn += int'(tx_done_tick);
    end
    check("brk_low_clk", 256'(lo), 256'(300));
    check("brk_mark_clk", 256'(hi >= 61 && hi <= 64), 256'(1));
    check("brk_no_done", 256'(dn), 256'(0));
    @(posedge clk); #1;

    // Start and break in the same cycle: break wins, frame follows afterwards
    send_break = 1'b1;
    fork
      send(9'h0FF, 8, 0, 0);
      begin
        @(negedge clk);
        check("brk_prio_ready", 256'(tx_ready), 256'(0));
        repeat (100) @(posedge clk); #1;
        check("brk_prio_line", 256'(tx), 256'(0));
        send_break = 1'b0;
      end
    join
    wait_idle();

    // Reset in the middle of the first data bit
    send(9'h0F0, 8, 0, 0);
    repeat (120) @(posedge clk); #1;
    check("rst_mid_pre", 256'(tx), 256'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tx", 256'(tx), 256'(1));
    check("rst_mid_busy", 256'(tx_busy), 256'(0));
    reset = 1'b0;
    check("rst_mid_ready", 256'(tx_ready), 256'(1));
    dn = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      dn += int'(tx_done_tick);
    end
    check("rst_mid_no_done", 256'(dn), 256'(0));
    @(posedge clk); #1;

    // Randomized frames, tick rates and CTS hold-offs
    for (int i = 0; i < 25; i++) begin
      tper = $urandom_range(2, 6);
      blk  = ($urandom_range(0, 3) == 0);
      gap  = $urandom_range(0, 2);
      k    = $urandom_range(1, 40);
      if (gap > 0) repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      if (i > 0 && gap == 0 && !blk) b2b_chk = 1'b1;
      fork
        send(9'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
        begin
          if (blk) begin
            cts = 1'b1;
            repeat (k) @(posedge clk);
            #1;
            cts = 1'b0;
          end
        end
      join
    end
    wait_idle();
    b2b_chk = 1'b0;
    check("queue_drained", 256'(expq.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
